dg0045_key_scanner: RTL and testbench
=====================================

// Module: dg0045_key_scanner
// PURPOSE
//  Keypad matrix scanner and debouncer; sits directly upstream of the DG0045 core's KIN input.
//  - Drives a 4x4 key matrix column by column and samples the raw rows.
//  - Debounces all 16 keys.
//  - Returns on KIN the debounced rows of whichever columns the core strobes on nL (active-low).
//  - Lets firmware read keys via L/KTA without software debounce or scan timing.
// PARAMETERS
//  SCAN_DIV  64  CLK_main cycles each column is driven (dwell); >=4
//  DEB_CNT   4   consecutive disagreeing samples needed to change a key's debounced state; >=1
// PORTS
//  CLK_main  in   1  system clock (same clock as core)
//  RESET     in   1  asynchronous, active-low reset
//  nL        in   4  core L outputs, active-low column select for KIN readback
//  ROW_RAW   in   4  raw matrix rows, async, 1 = key pressed
//  COL_N     out  4  matrix column drive, active-low, one-hot-low while scanning
//  KIN       out  4  debounced rows to core KIN
//  KEY_ANY   out  1  1 while any debounced key is pressed
//  KEY_EVT   out  1  1-cycle pulse when any debounced key state changes
// BEHAVIOUR
//  Reset values:
//  - COL_N=4'b1111; KIN=0; KEY_ANY=0; KEY_EVT=0.
//  - Debounced map deb[3:0][3:0]=0; per-key counters=0; col index=0; dwell counter=0; synchronizer=0.
//  ROW_RAW synchronization: 2-flop synchronizer; rs = stage-2 output.
//  Column scan:
//  - First cycle after RESET release: COL_N=4'b1110 (column 0).
//  - Dwell counter counts 0..SCAN_DIV-1 on CLK_main.
//  - At count SCAN_DIV-1, rs is sampled for the current column c (the SAMPLE cycle).
//  - Next cycle: column advances c->c+1 mod 4; COL_N = ~(1<<c); dwell counter -> 0.
//  - Full scan period = 4*SCAN_DIV cycles.
//  FSM per dwell: DRIVE (count<SCAN_DIV-1) -> SAMPLE (count==SCAN_DIV-1) -> DRIVE of next column.
//  - No idle state.
//  Debounce, applied per key (c,r) at its SAMPLE cycle:
//  - s==deb[c][r]: counter -> 0.
//  - s!=deb[c][r], counter < DEB_CNT-1: counter increments.
//  - s!=deb[c][r], counter == DEB_CNT-1: deb[c][r] <= s; counter -> 0.
//  - Counter width $clog2(DEB_CNT+1); it never wraps.
//  - Keys in other columns are untouched.
//  KEY_EVT: asserted the cycle after a SAMPLE in which >=1 deb bit changed.
//  - Exactly one pulse, even if several keys change at once.
//  KIN (registered, 1-cycle latency from nL or deb):
//  - KIN[r] = OR over all c with nL[c]==0 of deb[c][r].
//  - nL=4'b1111 -> KIN=0.
//  - Multiple low columns -> OR of those columns.
//  KEY_ANY (registered): OR of all 16 deb bits.
//  Boundaries:
//  - ROW_RAW glitch shorter than DEB_CNT samples: deb unchanged.
//  - Press and release of different keys on the same sample: both take effect; one KEY_EVT pulse.
//  - nL changes on the SAMPLE cycle: KIN reflects the new nL and the updated deb on the next cycle.
//  - RESET asserted mid-dwell: all state clears immediately; scan restarts at column 0.
// CONFIGURATION
//  GHOST_BLOCK_EN:
//  - Defined: a press acceptance (0->1) is refused if it would make the count of set deb bits
//    exceed 2. Key counter holds at DEB_CNT-1 and acceptance is retried on every later SAMPLE.
//    Releases are always accepted. Limits phantom keys in a diode-less matrix.
//  - Not defined: every qualifying change is accepted; no count logic is synthesized.
// TESTING (SCAN_DIV=8, DEB_CNT=3)
//  - Reset: hold RESET=0 -> COL_N=1111, KIN=0, KEY_ANY=0.
//    Release -> COL_N sequence 1110,1101,1011,0111 with 8-cycle dwells, repeating.
//  - Press key (c1,r2) steady, nL=4'b1101 -> KIN=4'b0100 after the 3rd column-1 SAMPLE (+1 cycle).
//    KEY_EVT pulses once; KEY_ANY=1. nL=1111 -> KIN=0.
//  - Bounce: key (c0,r0) asserted for 2 column-0 samples, then low -> deb stays 0; no KEY_EVT.
//  - Multi-column readback: keys (c0,r1) and (c3,r3) held; nL=4'b0110 -> KIN=4'b1010.
//    Release both -> KIN=0 after 3 samples of each column.
//  - Reset mid-operation: RESET=0 at dwell count 5 of column 2 with keys debounced ->
//    all outputs 0 at once; scan restarts at column 0.
//  - GHOST_BLOCK_EN defined: hold 3 keys -> only the first 2 accepted.
//    Release one -> third accepted on its next SAMPLE.

Source files
------------

// File: rtl/dg0045_key_scanner.sv
// 4x4 keypad scanner and debouncer feeding the DG0045 core KIN input.
// Optional press limiting for diode-less matrices: define GHOST_BLOCK_EN.
module dg0045_key_scanner #(
  parameter int SCAN_DIV = 64,
  parameter int DEB_CNT  = 4
) (
  input  logic       CLK_main,
  input  logic       RESET,
  input  logic [3:0] nL,
  input  logic [3:0] ROW_RAW,
  output logic [3:0] COL_N,
  output logic [3:0] KIN,
  output logic       KEY_ANY,
  output logic       KEY_EVT
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int KW = $clog2(DEB_CNT + 1);
  localparam logic [DW-1:0] DPRE  = DW'(SCAN_DIV - 2);
  localparam logic [KW-1:0] KLAST = KW'(DEB_CNT - 1);

  typedef enum logic {
    DRIVE,
    SAMPLE
  } state_t;

  state_t state;
  logic             run;
  logic [DW-1:0]    cnt;
  logic [1:0]       col;
  logic [1:0]       col_inc;
  logic [3:0]       sync1;
  logic [3:0]       rs;
  logic [3:0][3:0]  deb;
  logic [3:0][3:0]  deb_nx;
  logic [3:0][3:0][KW-1:0] kc;
  logic [3:0][3:0][KW-1:0] kc_nx;
  logic [3:0]       due;
  logic [3:0]       kin_nx;
`ifdef GHOST_BLOCK_EN
  logic [4:0]       ones;
`endif

  assign col_inc = col + 2'd1;

  always_comb begin
    deb_nx = deb;
    kc_nx  = kc;
    due    = '0;
`ifdef GHOST_BLOCK_EN
    ones = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ones = ones + 5'(deb[c][r]);
`endif
    if (state == SAMPLE) begin
      for (int r = 0; r < 4; r++) begin
        if (rs[r] == deb[col][r])
          kc_nx[col][r] = '0;
        else if (kc[col][r] != KLAST)
          kc_nx[col][r] = kc[col][r] + KW'(1);
        else
          due[r] = 1'b1;
      end
`ifdef GHOST_BLOCK_EN
      // releases first so a swap within one column is not refused
      for (int r = 0; r < 4; r++) begin
        if (due[r] && !rs[r]) begin
          deb_nx[col][r] = 1'b0;
          kc_nx[col][r]  = '0;
          ones           = ones - 5'd1;
        end
      end
      for (int r = 0; r < 4; r++) begin
        if (due[r] && rs[r] && ones < 5'd2) begin
          deb_nx[col][r] = 1'b1;
          kc_nx[col][r]  = '0;
          ones           = ones + 5'd1;
        end
      end
`else
      for (int r = 0; r < 4; r++) begin
        if (due[r]) begin
          deb_nx[col][r] = rs[r];
          kc_nx[col][r]  = '0;
        end
      end
`endif
    end
    kin_nx = '0;
    for (int c = 0; c < 4; c++)
      if (!nL[c]) kin_nx = kin_nx | deb_nx[c];
  end

  always_ff @(posedge CLK_main or negedge RESET) begin
    if (!RESET) begin
      state   <= DRIVE;
      run     <= 1'b0;
      cnt     <= '0;
      col     <= '0;
      sync1   <= '0;
      rs      <= '0;
      deb     <= '0;
      kc      <= '0;
      COL_N   <= 4'b1111;
      KIN     <= '0;
      KEY_ANY <= 1'b0;
      KEY_EVT <= 1'b0;
    end else begin
      sync1   <= ROW_RAW;
      rs      <= sync1;
      deb     <= deb_nx;
      kc      <= kc_nx;
      KIN     <= kin_nx;
      KEY_ANY <= |deb_nx;
      KEY_EVT <= (deb_nx != deb);
      if (!run) begin
        run   <= 1'b1;
        COL_N <= 4'b1110;
      end else begin
        unique case (state)
          DRIVE: begin
            cnt <= cnt + DW'(1);
            if (cnt == DPRE) state <= SAMPLE;
          end
          SAMPLE: begin
            cnt   <= '0;
            col   <= col_inc;
            COL_N <= ~(4'b0001 << col_inc);
            state <= DRIVE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dg0045_key_scanner.sv
// Directed bench for dg0045_key_scanner (SCAN_DIV=8, DEB_CNT=3).
// Keys are modelled as a passive matrix answering the driven column.
module tb_dg0045_key_scanner;

  logic       CLK_main = 1'b0;
  logic       RESET;
  logic [3:0] nL;
  logic [3:0] ROW_RAW;
  logic [3:0] COL_N;
  logic [3:0] KIN;
  logic       KEY_ANY;
  logic       KEY_EVT;

  logic [3:0][3:0] keys;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int evts = 0;
  int e0;
  logic [3:0] e;

  dg0045_key_scanner #(.SCAN_DIV(8), .DEB_CNT(3)) dut (
    .CLK_main(CLK_main),
    .RESET(RESET),
    .nL(nL),
    .ROW_RAW(ROW_RAW),
    .COL_N(COL_N),
    .KIN(KIN),
    .KEY_ANY(KEY_ANY),
    .KEY_EVT(KEY_EVT)
  );

  always #5 CLK_main = ~CLK_main;

  always_comb begin
    ROW_RAW = '0;
    for (int c = 0; c < 4; c++)
      if (!COL_N[c]) ROW_RAW = ROW_RAW | keys[c];
  end

  always @(negedge CLK_main) if (KEY_EVT) evts++;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_main);
    #1;
    cyc++;
  endtask

  // edge n (counted from reset release) samples column c
  function automatic bit is_samp(input int n, input int c);
    return n >= 9 && (n - 1) % 8 == 0 && ((n - 1) / 8 - 1) % 4 == c;
  endfunction

  task automatic after_sample(input int c);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      hit = is_samp(cyc, c);
    end
    if (!hit) begin
      errors++;
      $error("FAIL wait_sample col=%0d observed=timeout expected=sample", c);
    end
  endtask

  task automatic pre_sample(input int c);
    bit hit = is_samp(cyc + 1, c);
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      hit = is_samp(cyc + 1, c);
    end
    if (!hit) begin
      errors++;
      $error("FAIL pre_sample col=%0d observed=timeout expected=sample", c);
    end
  endtask

  initial begin
    RESET = 1'b0;
    nL    = 4'b1111;
    keys  = '0;
    repeat (3) tick();
    check("rst_col_n", 8'(COL_N), 8'hF);
    check("rst_kin", 8'(KIN), 8'h0);
    check("rst_any", 8'(KEY_ANY), 8'h0);
    check("rst_evt", 8'(KEY_EVT), 8'h0);

    RESET = 1'b1;
    cyc = 0;
    for (int n = 1; n <= 32; n++) begin
      tick();
      e = 4'b0001 << (((cyc - 1) / 8) % 4);
      e = ~e;
      check("scan_col_n", 8'(COL_N), 8'(e));
    end

    after_sample(3);
    keys[1][2] = 1'b1;
    nL = 4'b1101;
    e0 = evts;
    after_sample(1);
    check("press_s1_kin", 8'(KIN), 8'h0);
    check("press_s1_evt", 8'(KEY_EVT), 8'h0);
    after_sample(1);
    check("press_s2_kin", 8'(KIN), 8'h0);
    after_sample(1);
    check("press_kin", 8'(KIN), 8'h4);
    check("press_evt", 8'(KEY_EVT), 8'h1);
    check("press_any", 8'(KEY_ANY), 8'h1);
    tick();
    check("press_evt_end", 8'(KEY_EVT), 8'h0);
    check("press_evt_cnt", 8'(evts - e0), 8'h1);
    nL = 4'b1111;
    tick();
    check("nl_off_kin", 8'(KIN), 8'h0);
    keys[1][2] = 1'b0;
    after_sample(1);
    after_sample(1);
    check("rel_s2_any", 8'(KEY_ANY), 8'h1);
    after_sample(1);
    check("rel_evt", 8'(KEY_EVT), 8'h1);
    check("rel_any", 8'(KEY_ANY), 8'h0);

    after_sample(3);
    keys[0][0] = 1'b1;
    nL = 4'b1110;
    e0 = evts;
    after_sample(0);
    after_sample(0);
    keys[0][0] = 1'b0;
    after_sample(0);
    after_sample(0);
    after_sample(3);
    keys[0][0] = 1'b1;
    after_sample(0);
    keys[0][0] = 1'b0;
    after_sample(0);
    tick();
    check("bounce_kin", 8'(KIN), 8'h0);
    check("bounce_any", 8'(KEY_ANY), 8'h0);
    check("bounce_evt_cnt", 8'(evts - e0), 8'h0);

    after_sample(3);
    keys[0][1] = 1'b1;
    keys[3][3] = 1'b1;
    nL = 4'b0110;
    e0 = evts;
    repeat (3) after_sample(3);
    check("multi_kin", 8'(KIN), 8'hA);
    check("multi_any", 8'(KEY_ANY), 8'h1);
    tick();
    check("multi_evt_cnt", 8'(evts - e0), 8'h2);

    keys[0][1] = 1'b0;
    keys[0][2] = 1'b1;
    e0 = evts;
    after_sample(0);
    after_sample(0);
    pre_sample(0);
    nL = 4'b1110;
    tick();
    check("swap_kin", 8'(KIN), 8'h4);
    check("swap_evt", 8'(KEY_EVT), 8'h1);
    tick();
    check("swap_evt_cnt", 8'(evts - e0), 8'h1);
    check("swap_any", 8'(KEY_ANY), 8'h1);

    keys = '0;
    nL = 4'b0110;
    repeat (3) after_sample(0);
    tick();
    check("clr_kin", 8'(KIN), 8'h0);
    check("clr_any", 8'(KEY_ANY), 8'h0);

    keys[1][2] = 1'b1;
    nL = 4'b1101;
    repeat (3) after_sample(1);
    check("pre_rst_kin", 8'(KIN), 8'h4);
    for (int i = 0; i < 40; i++) begin
      if ((cyc - 1) % 8 == 5 && ((cyc - 1) / 8) % 4 == 2) break;
      tick();
    end
    check("rst_mid_col_n_pre", 8'(COL_N), 8'hB);
    #1 RESET = 1'b0;
    #1;
    check("rst_mid_col_n", 8'(COL_N), 8'hF);
    check("rst_mid_kin", 8'(KIN), 8'h0);
    check("rst_mid_any", 8'(KEY_ANY), 8'h0);
    check("rst_mid_evt", 8'(KEY_EVT), 8'h0);
    keys = '0;
    tick();
    tick();
    check("rst_hold_col_n", 8'(COL_N), 8'hF);
    RESET = 1'b1;
    cyc = 0;
    tick();
    check("restart_col_n", 8'(COL_N), 8'hE);
    check("restart_kin", 8'(KIN), 8'h0);
    repeat (8) tick();
    check("restart_col1", 8'(COL_N), 8'hD);

`ifdef GHOST_BLOCK_EN
    after_sample(3);
    keys[0][0] = 1'b1;
    keys[1][1] = 1'b1;
    keys[2][2] = 1'b1;
    nL = 4'b1000;
    repeat (3) after_sample(2);
    check("ghost_kin", 8'(KIN), 8'h3);
    repeat (2) after_sample(2);
    check("ghost_hold_kin", 8'(KIN), 8'h3);
    keys[0][0] = 1'b0;
    repeat (3) after_sample(0);
    check("ghost_rel_kin", 8'(KIN), 8'h2);
    after_sample(2);
    check("ghost_retry_kin", 8'(KIN), 8'h6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
